// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared widths, FSM states and shift operation helpers
//
// Purpose: common definitions for the shift normalizer.
// Contents:
//   DATA_WIDTH, CNT_WIDTH  operand and shift-count widths
//   state_e                normalizer FSM states
//   shift_op_e             one-bit shift operation encodings
//   shift1()               apply one shift operation to a word
//   target_set()           test the normalization target bit for a mode
package shifter_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shift_op_e;

  function automatic logic [DATA_WIDTH-1:0] shift1(input shift_op_e op,
                                                   input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = v;
    case (op)
      OP_ROL:  r = {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
      OP_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
      OP_ROR:  r = {v[0], v[DATA_WIDTH-1:1]};
      OP_SRL:  r = {1'b0, v[DATA_WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // mode 0 normalizes toward the MSB, mode 1 toward the LSB.
  function automatic logic target_set(input logic m, input logic [DATA_WIDTH-1:0] v);
    return m ? v[0] : v[DATA_WIDTH-1];
  endfunction

endpackage

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - iterative one-bit-per-cycle operand normalizer
//
// Purpose: shifts an operand left until bit15 is set (mode 0) or right
// until bit0 is set (mode 1), reporting the shift count and a zero flag.
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   inValid      request valid
//   inReady      request accepted when high (IDLE only)
//   dataIn       operand to normalize
//   mode         0 = normalize left, 1 = normalize right
//   outValid     result valid (DONE only)
//   outReady     consumer accepts result
//   dataOut      normalized operand
//   shiftAmount  number of 1-bit shifts applied
//   zero         operand was all zeros
module shift_normalizer
  import shifter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  mode,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [CNT_WIDTH-1:0]  shiftAmount,
  output logic                  zero
);

  state_e                state;
  logic [DATA_WIDTH-1:0] work;
  logic [CNT_WIDTH-1:0]  count;
  logic                  zero_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] shifted;

  // Logical shifts only: vacated bits fill with zero.
  assign shifted = shift1(mode_q ? OP_SRL : OP_SLL, work);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      work   <= '0;
      count  <= '0;
      zero_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inValid) begin
            work   <= dataIn;
            mode_q <= mode;
            count  <= '0;
            zero_q <= 1'b0;
            if (dataIn == '0) begin
              zero_q <= 1'b1;
              state  <= ST_DONE;
            end else if (target_set(mode, dataIn)) begin
              state <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          // Work is nonzero here, so the target bit is reached within 15
          // shifts and the counter cannot wrap.
          work  <= shifted;
          count <= count + 1'b1;
          if (target_set(mode_q, shifted)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (outReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign inReady     = (state == ST_IDLE);
  assign outValid    = (state == ST_DONE);
  assign dataOut     = work;
  assign shiftAmount = count;
  assign zero        = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - self-checking bench for shift_normalizer
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [15:0] dataIn;
  logic        mode;
  logic        outValid;
  logic        outReady;
  logic [15:0] dataOut;
  logic [3:0]  shiftAmount;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  shift_normalizer dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .mode(mode), .outValid(outValid), .outReady(outReady),
    .dataOut(dataOut), .shiftAmount(shiftAmount), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  amt;
    logic        z;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: normalizing moves the highest (mode 0) or lowest (mode 1)
  // set bit to the target end; the distance moved is the shift count.
  task automatic model(input logic m, input logic [15:0] d, output vec_t v);
    int pos;
    v.m = m; v.din = d;
    if (d == 0) begin
      v.dout = 0; v.amt = 0; v.z = 1; v.lat = 1;
      return;
    end
    pos = -1;
    for (int i = 0; i < 16; i++) begin
      if (d[i] && (m ? (pos < 0) : 1'b1)) pos = i;
    end
    if (m == 1'b0) begin
      v.amt  = 4'(15 - pos);
      v.dout = d << (15 - pos);
    end else begin
      v.amt  = 4'(pos);
      v.dout = d >> pos;
    end
    v.z = 0;
    v.lat = int'(v.amt) + 1;
  endtask

  // Issue one request, wait for the result, release it. Latency counts
  // edges from and including the accept edge until outValid is seen.
  task automatic run_req(input logic m, input logic [15:0] d,
                         output logic [15:0] o, output logic [3:0] a,
                         output logic z, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", 32'(inReady), 1);
    inValid = 1'b1; dataIn = d; mode = m; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0; dataIn = $urandom; mode = $urandom;
    lat = 1;
    while (!outValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    o = dataOut; a = shiftAmount; z = zero;
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    check("idle_after_release", 32'({inReady, outValid}), 32'b10);
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [15:0] o; logic [3:0] a; logic z; int lat;
    run_req(v.m, v.din, o, a, z, lat);
    check({tag, "_dout"}, 32'(o), 32'(v.dout));
    check({tag, "_amt"},  32'(a), 32'(v.amt));
    check({tag, "_zero"}, 32'(z), 32'(v.z));
    check({tag, "_lat"},  32'(lat), 32'(v.lat));
  endtask

  vec_t vecs[5];

  initial begin
    logic [15:0] held_d; logic [3:0] held_a;
    logic [15:0] o; logic [3:0] a; logic z; int lat;
    vec_t v;

    vecs[0] = '{m:1'b0, din:16'h0001, dout:16'h8000, amt:4'd15, z:1'b0, lat:16};
    vecs[1] = '{m:1'b0, din:16'h8000, dout:16'h8000, amt:4'd0,  z:1'b0, lat:1};
    vecs[2] = '{m:1'b0, din:16'h0000, dout:16'h0000, amt:4'd0,  z:1'b1, lat:1};
    vecs[3] = '{m:1'b1, din:16'h0000, dout:16'h0000, amt:4'd0,  z:1'b1, lat:1};
    vecs[4] = '{m:1'b1, din:16'h0A00, dout:16'h0005, amt:4'd9,  z:1'b0, lat:10};

    rst_n = 1'b0; inValid = 1'b0; dataIn = 16'hFFFF; mode = 1'b1; outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({inReady, outValid, zero, shiftAmount, dataOut}), 32'({1'b1, 1'b0, 1'b0, 4'd0, 16'd0}));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'h0;
        1: d = 16'h1 << $urandom_range(0, 15);
        default: d = 16'($urandom);
      endcase
      model(1'($urandom), d, v);
      run_req(v.m, d, o, a, z, lat);
      check($sformatf("rnd%0d", i), 32'({o, a, z}), 32'({v.dout, v.amt, v.z}));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(v.lat));
      if (d != 0)
        check($sformatf("rnd%0d_inv", i), 32'(v.m ? (o << a) : (o >> a)), 32'(d));
    end

    // Stall in DONE with a competing request pending.
    @(negedge clk);
    inValid = 1'b1; dataIn = 16'h0040; mode = 1'b0;
    @(posedge clk); #1;
    dataIn = 16'h1234; mode = 1'b1;
    lat = 1;
    while (!outValid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("stall_lat", 32'(lat), 10);
    held_d = dataOut; held_a = shiftAmount;
    check("stall_result", 32'({held_d, held_a}), 32'({16'h8000, 4'd9}));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_hold", 32'({outValid, inReady, dataOut, shiftAmount, zero}),
            32'({1'b1, 1'b0, held_d, held_a, 1'b0}));
    end
    @(negedge clk); inValid = 1'b0; outReady = 1'b1;
    @(posedge clk); #1; outReady = 1'b0;
    check("stall_release", 32'({inReady, outValid}), 32'b10);

    // Reset mid-shift abandons the operation.
    @(negedge clk);
    inValid = 1'b1; dataIn = 16'h0001; mode = 1'b0;
    @(posedge clk); #1; inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(inReady), 0);
    rst_n = 1'b0; #1;
    check("async_reset", 32'({inReady, outValid, zero, shiftAmount, dataOut}), 32'({1'b1, 1'b0, 1'b0, 4'd0, 16'd0}));
    inValid = 1'b1; dataIn = 16'h4000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ignores_in", 32'({outValid, dataOut}), 32'({1'b0, 16'd0}));
    @(negedge clk); inValid = 1'b0; rst_n = 1'b1;
    vecs[0] = '{m:1'b0, din:16'h0100, dout:16'h8000, amt:4'd7, z:1'b0, lat:8};
    apply(vecs[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 Ports SHALL be: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 inValid  input  1  request valid.
REQ-004 inReady  output  1  block can accept a request; high only in IDLE.
REQ-005 dataIn  input  16  operand to normalize.
REQ-006 mode  input  1  0 = normalize left (until bit15 set), 1 = normalize right (until bit0 set).
REQ-007 outValid  output  1  result valid.
REQ-008 outReady  input  1  consumer accepts result.
REQ-009 dataOut  output  16  normalized operand.
REQ-010 shiftAmount  output  4  number of 1-bit shifts applied, 0..15.
REQ-011 zero  output  1  operand was all zeros.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; inReady = (state == IDLE); outValid = (state == DONE).
REQ-013 Accept SHALL occur on an edge with inValid && inReady; dataIn and mode are captured, shiftAmount cleared, zero cleared.
REQ-014 On accept with dataIn == 0: next state DONE, dataOut 0, shiftAmount 0, zero 1.
REQ-015 On accept with target bit already set (bit15 for mode 0, bit0 for mode 1): next state DONE, dataOut = dataIn, shiftAmount 0.
REQ-016 Otherwise: next state SHIFT, working register = dataIn.
REQ-017 Each SHIFT edge: mode 0 shifts the working register left 1 (zero fill at bit0); mode 1 shifts right 1 (zero fill at bit15); shiftAmount increments by 1.
REQ-018 SHIFT SHALL transition to DONE on the edge where the shifted value has its target bit set; no other exit except reset.
REQ-019 Latency: outValid SHALL rise exactly k+1 edges after the accept edge, k = final shiftAmount (max 16 edges).
REQ-020 In DONE, dataOut, shiftAmount, zero SHALL hold stable until an edge with outReady high, which returns state to IDLE.
REQ-021 inValid SHALL be ignored outside IDLE; one request in flight at a time; no same-edge result-release and new accept (IDLE entered first).
REQ-022 shiftAmount SHALL never wrap; a nonzero operand reaches its target bit within 15 shifts.
REQ-023 Invariant: for nonzero input, mode 0 dataOut logically shifted right by shiftAmount equals dataIn; mode 1 dataOut logically shifted left by shiftAmount equals dataIn.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, outValid 0, dataOut 0x0000, shiftAmount 0, zero 0, captured mode 0.
REQ-025 Reset mid-SHIFT or mid-DONE SHALL abandon the operation with no result produced; inReady reads 1 after reset.
REQ-026 Inputs SHALL be ignored while rst_n is low; first accept possible on the first rising edge with rst_n high.

Structure
REQ-027 Shared package shifter_pkg SHALL hold DATA_WIDTH = 16, CNT_WIDTH = 4, the FSM state enum, and the shift operation encodings (rotate left 00, logical left 01, rotate right 10, logical right 11).
REQ-028 No sub-module; single module with one state register, one 16-bit working register, one 4-bit counter.

Verification
REQ-029 mode 0, dataIn 0x0001 -> dataOut 0x8000, shiftAmount 15, zero 0, outValid 16 edges after accept.
REQ-030 mode 0, dataIn 0x8000 -> dataOut 0x8000, shiftAmount 0, outValid 1 edge after accept.
REQ-031 dataIn 0x0000, both modes -> dataOut 0x0000, shiftAmount 0, zero 1, latency 1.
REQ-032 mode 1, dataIn 0x0A00 -> dataOut 0x0005, shiftAmount 9, latency 10.
REQ-033 outReady low 5 cycles in DONE with inValid high -> outputs stable, inReady 0, no accept; outReady high -> IDLE next edge.
REQ-034 mode 0, dataIn 0x0001, rst_n low 4 edges after accept -> outValid 0 and all outputs 0 immediately; subsequent request 0x0100 -> 0x8000, shiftAmount 7.
